// File: rtl/inv_conv_pkg.sv
// Shared widths and helpers for the Booth-4 operand negator.
package inv_conv_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned INV_W  = 17;
   localparam int unsigned SPLIT  = 8;

   function automatic logic [INV_W-1:0] sext17(input logic [DATA_W-1:0] a);
      return {a[DATA_W-1], a};
   endfunction

endpackage

// File: rtl/inv_converter_16_sync_inc_n.sv
// Combinational N-bit incrementer (sum = a + cin) with a prefix-AND carry chain.
module inc_n #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] i_a,
   input  logic         i_cin,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);

   logic         w_c;
   logic [N-1:0] w_sum;

   always_comb begin
      w_c   = i_cin;
      w_sum = '0;
      for (int k = 0; k < int'(N); k++) begin
         w_sum[k] = i_a[k] ^ w_c;
         w_c      = w_c & i_a[k];
      end
   end

   assign o_sum  = w_sum;
   assign o_cout = w_c;

endmodule

// File: rtl/inv_converter_16_sync.sv
// Registered two's-complement negator: inv_o = -sext(data_i), 17-bit exact result.
// Define INV_CONV_PIPE2_EN to split the +1 carry chain over two stages (latency 2).
module inv_converter_16_sync
   import inv_conv_pkg::*;
(
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [INV_W-1:0]  inv_o
);

   logic [INV_W-1:0] w_inv;
   logic             r_valid;
   logic [INV_W-1:0] r_inv;

   assign w_inv = ~sext17(data_i);

`ifdef INV_CONV_PIPE2_EN
   logic [SPLIT-1:0]       w_lo_sum;
   logic                   w_lo_cout;
   logic [INV_W-SPLIT-1:0] w_hi_sum;
   logic                   w_unused_cout;
   logic [SPLIT-1:0]       r_s1_lo;
   logic                   r_s1_c;
   logic [INV_W-SPLIT-1:0] r_s1_hi;
   logic                   r_s1_valid;

   inc_n #(
      .N (SPLIT)
   ) u_inc_lo (
      .i_a    (w_inv[SPLIT-1:0]),
      .i_cin  (1'b1),
      .o_sum  (w_lo_sum),
      .o_cout (w_lo_cout)
   );

   // Stage 1: low byte finished, its carry waits alongside the inverted high bits.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_s1_lo    <= '0;
         r_s1_c     <= 1'b0;
         r_s1_hi    <= '0;
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_lo    <= w_lo_sum;
         r_s1_c     <= w_lo_cout;
         r_s1_hi    <= w_inv[INV_W-1:SPLIT];
         r_s1_valid <= valid_i;
      end
   end

   inc_n #(
      .N (INV_W - SPLIT)
   ) u_inc_hi (
      .i_a    (r_s1_hi),
      .i_cin  (r_s1_c),
      .o_sum  (w_hi_sum),
      .o_cout (w_unused_cout)
   );

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_valid <= 1'b0;
         r_inv   <= '0;
      end else begin
         r_valid <= r_s1_valid;
         r_inv   <= {w_hi_sum, r_s1_lo};
      end
   end
`else
   logic [INV_W-1:0] w_sum;
   logic             w_unused_cout;

   inc_n #(
      .N (INV_W)
   ) u_inc (
      .i_a    (w_inv),
      .i_cin  (1'b1),
      .o_sum  (w_sum),
      .o_cout (w_unused_cout)
   );

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_valid <= 1'b0;
         r_inv   <= '0;
      end else begin
         r_valid <= valid_i;
         r_inv   <= w_sum;
      end
   end
`endif

   assign valid_o = r_valid;
   assign inv_o   = r_inv;

endmodule

// File: tb/tb_inv_converter_16_sync.sv
// Scoreboard bench for inv_converter_16_sync; works in both latency builds.
module tb_inv_converter_16_sync;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        valid_i;
   logic [15:0] data_i;
   logic        valid_o;
   logic [16:0] inv_o;

   int          n_tests;
   int          n_fail;
   logic [16:0] exp_q[$];

   inv_converter_16_sync u_dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .valid_i   (valid_i),
      .data_i    (data_i),
      .valid_o   (valid_o),
      .inv_o     (inv_o)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Reference: plain integer negation, truncated to 17 bits.
   function automatic logic [16:0] neg_ref(input logic [15:0] d);
      int v;
      v = -int'($signed(d));
      return v[16:0];
   endfunction

   task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic send(input logic v, input logic [15:0] d, input logic [16:0] exp);
      valid_i = v;
      data_i  = d;
      if (v) exp_q.push_back(exp);
      @(posedge sys_clk);
      #1;
   endtask

   task automatic reset_pulse();
      sys_rst_n = 1'b0;
      valid_i   = 1'b1;
      data_i    = 16'(($urandom));
      @(posedge sys_clk);
      #1;
      check("rst_valid", {16'h0, valid_o}, 17'h0);
      check("rst_inv", inv_o, 17'h0);
      exp_q.delete();
      sys_rst_n = 1'b1;
   endtask

   // Monitor: pops one expectation per presented result.
   always @(negedge sys_clk) begin
      if (sys_rst_n && valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", {16'h0, valid_o}, 17'h0);
         end else begin
            check("result", inv_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      int n_valid;
      logic [15:0] d;
      logic        v;
      n_tests   = 0;
      n_fail    = 0;
      sys_rst_n = 1'b0;
      valid_i   = 1'b1;
      data_i    = 16'h1234;

      for (int i = 0; i < 3; i++) begin
         @(posedge sys_clk);
         #1;
         check("reset_valid", {16'h0, valid_o}, 17'h0);
         check("reset_inv", inv_o, 17'h0);
      end
      sys_rst_n = 1'b1;
      valid_i   = 1'b0;

      send(1'b1, 16'h8000, 17'h08000);
      send(1'b0, 16'h0000, 17'h0);
      send(1'b1, 16'h0000, 17'h00000);
      send(1'b1, 16'h0001, 17'h1FFFF);
      send(1'b1, 16'h7FFF, 17'h18001);
      send(1'b1, 16'hFFFF, 17'h00001);
      send(1'b0, 16'h0000, 17'h0);

      send(1'b1, 16'd5,    17'h1FFFB);
      send(1'b1, 16'hFFFB, 17'h00005);
      send(1'b1, 16'd100,  17'h1FF9C);
      send(1'b1, 16'h8001, 17'h07FFF);

      for (int i = 0; i < 4; i++) begin
         d = 16'($urandom);
         send(1'b1, d, neg_ref(d));
      end
      reset_pulse();
      // Stage-1 contents were cleared too, so nothing may appear here.
      send(1'b0, 16'h0000, 17'h0);
      send(1'b0, 16'h0000, 17'h0);
      for (int i = 0; i < 6; i++) begin
         d = 16'($urandom);
         send(1'b1, d, neg_ref(d));
      end

      n_valid = 0;
      while (n_valid < 65536) begin
         v = ($urandom_range(0, 7) != 0);
         d = 16'($urandom);
         send(v, d, neg_ref(d));
         if (v) n_valid++;
      end
      valid_i = 1'b0;

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(posedge sys_clk);
         #1;
      end
      check("drain_empty", 17'(exp_q.size()), 17'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
